// File: rtl/io_uart_irq.sv
`timescale 1ns/1ps
// io_uart_irq: UART on the J1 IO bus. Holds one TX byte plus a shifter,
// receives into a small FIFO, and raises a level interrupt to the core.
// Register reads are combinational so the core can latch io_din on the
// access edge.
module io_uart_irq #(
  parameter logic [7:0]  BASE        = 8'h10,
  parameter int          RXAW        = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        interrupt_request,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int DEPTH = 1 << RXAW;
  localparam logic [RXAW:0] FIFO_FULL = (RXAW+1)'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus decode ----------------
  logic       sel;
  logic [1:0] reg_idx;
  logic       data_wr, stat_wr, div_wr, ie_wr, data_rd;

  assign sel     = (io_addr[15:8] == BASE);
  assign reg_idx = io_addr[2:1];
  assign data_wr = sel && io_wr && (reg_idx == 2'd0);
  assign stat_wr = sel && io_wr && (reg_idx == 2'd1);
  assign div_wr  = sel && io_wr && (reg_idx == 2'd2);
  assign ie_wr   = sel && io_wr && (reg_idx == 2'd3);
  assign data_rd = sel && io_rd && (reg_idx == 2'd0);

  // Address bits that play no part in decode.
  logic unused_addr;
  assign unused_addr = ^{io_addr[7:3], io_addr[0]};

  // ---------------- control registers ----------------
  logic [15:0] div_reg;
  logic [1:0]  ie_reg;

  // Baud divisor and interrupt enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= DEFAULT_DIV;
      ie_reg  <= 2'b00;
    end else begin
      if (div_wr) div_reg <= io_dout;
      if (ie_wr)  ie_reg  <= io_dout[1:0];
    end
  end

  // ---------------- TX path ----------------
  tx_state_t   tx_state_reg;
  logic [7:0]  tx_hold_reg;
  logic        tx_full_reg;
  logic [7:0]  tx_shift_reg;
  logic [15:0] tx_cnt_reg;
  logic [2:0]  tx_bit_reg;
  logic        txd_reg;
  logic        tx_tick;
  logic        tx_load;
  logic        tx_ready;
  logic        tx_idle;

  assign tx_tick  = (tx_cnt_reg == 16'd0);
  // The shifter takes the held byte from IDLE, or straight out of a finished STOP.
  assign tx_load  = tx_full_reg &&
                    ((tx_state_reg == TX_IDLE) || ((tx_state_reg == TX_STOP) && tx_tick));
  assign tx_ready = !tx_full_reg;
  assign tx_idle  = !tx_full_reg && (tx_state_reg == TX_IDLE);

  // Holding register: filled by a DATA write when empty, emptied when the shifter loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_full_reg <= 1'b0;
      tx_hold_reg <= 8'h00;
    end else if (tx_load) begin
      tx_full_reg <= 1'b0;
    end else if (data_wr && !tx_full_reg) begin
      tx_full_reg <= 1'b1;
      tx_hold_reg <= io_dout[7:0];
    end
  end

  // TX FSM: start bit, 8 data bits LSB first, stop bit; each bit DIV+1 clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= 8'h00;
      tx_cnt_reg   <= 16'd0;
      tx_bit_reg   <= 3'd0;
      txd_reg      <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (tx_full_reg) begin
            tx_state_reg <= TX_START;
            tx_shift_reg <= tx_hold_reg;
            tx_cnt_reg   <= div_reg;
            txd_reg      <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_state_reg <= TX_DATA;
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_bit_reg   <= 3'd0;
            tx_cnt_reg   <= div_reg;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt_reg <= div_reg;
            if (tx_bit_reg == 3'd7) begin
              tx_state_reg <= TX_STOP;
              txd_reg      <= 1'b1;
            end else begin
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
              tx_bit_reg   <= tx_bit_reg + 3'd1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            if (tx_full_reg) begin
              tx_state_reg <= TX_START;
              tx_shift_reg <= tx_hold_reg;
              tx_cnt_reg   <= div_reg;
              txd_reg      <= 1'b0;
            end else begin
              tx_state_reg <= TX_IDLE;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign uart_txd = txd_reg;

  // ---------------- RX path ----------------
  logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
  rx_state_t   rx_state_reg;
  logic [7:0]  rx_shift_reg;
  logic [15:0] rx_cnt_reg;
  logic [2:0]  rx_bit_reg;
  logic        rx_tick;
  logic        rx_stop_ok, rx_stop_bad;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= uart_rxd;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  assign rx_tick     = (rx_cnt_reg == 16'd0);
  assign rx_stop_ok  = (rx_state_reg == RX_STOP) && rx_tick && rx_s2_reg;
  assign rx_stop_bad = (rx_state_reg == RX_STOP) && rx_tick && !rx_s2_reg;

  // RX FSM: half-bit start check, then one sample per bit period.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg <= RX_IDLE;
      rx_shift_reg <= 8'h00;
      rx_cnt_reg   <= 16'd0;
      rx_bit_reg   <= 3'd0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_s2_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= {1'b0, div_reg[15:1]};
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (rx_s2_reg) begin
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_state_reg <= RX_DATA;
              rx_bit_reg   <= 3'd0;
              rx_cnt_reg   <= div_reg;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
            rx_cnt_reg   <= div_reg;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
            else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_tick) rx_state_reg <= RX_IDLE;
          else         rx_cnt_reg   <= rx_cnt_reg - 16'd1;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]      rx_mem [DEPTH];
  logic [RXAW-1:0] rx_wptr_reg, rx_rptr_reg;
  logic [RXAW:0]   rx_count_reg;
  logic            rx_valid, rx_full;
  logic            rx_pop, rx_push, rx_ovf_set;

  assign rx_valid   = (rx_count_reg != '0);
  assign rx_full    = (rx_count_reg == FIFO_FULL);
  assign rx_pop     = data_rd && rx_valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign rx_push    = rx_stop_ok && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_stop_ok && rx_full && !rx_pop;

  // FIFO storage write port (no reset so it maps to RAM).
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_reg] <= rx_shift_reg;
  end

  // FIFO pointers and fill count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr_reg  <= '0;
      rx_rptr_reg  <= '0;
      rx_count_reg <= '0;
    end else begin
      if (rx_push) rx_wptr_reg <= rx_wptr_reg + 1'b1;
      if (rx_pop)  rx_rptr_reg <= rx_rptr_reg + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
        2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end

  // ---------------- sticky flags and IRQ ----------------
  logic rx_ovf_reg, frame_err_reg, irq_reg;

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_ovf_reg    <= rx_ovf_set  || (rx_ovf_reg    && !(stat_wr && io_dout[2]));
      frame_err_reg <= rx_stop_bad || (frame_err_reg && !(stat_wr && io_dout[3]));
    end
  end

  // Level interrupt, registered one clock behind its condition.
  always_ff @(posedge clk) begin
    if (reset) irq_reg <= 1'b0;
    else       irq_reg <= (ie_reg[0] && rx_valid) || (ie_reg[1] && tx_ready);
  end

  assign interrupt_request = irq_reg;

  // ---------------- read mux ----------------
  // Zero whenever not addressed so several peripherals can be OR-ed together.
  always_comb begin
    io_din = 16'h0000;
    if (sel && io_rd) begin
      case (reg_idx)
        2'd0:    io_din = rx_valid ? {8'h00, rx_mem[rx_rptr_reg]} : 16'h0000;
        2'd1:    io_din = {8'(rx_count_reg), 3'b000, tx_idle, frame_err_reg,
                           rx_ovf_reg, rx_valid, tx_ready};
        2'd2:    io_din = div_reg;
        default: io_din = {14'h0000, ie_reg};
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_irq.sv
`timescale 1ns/1ps
// Bench for io_uart_irq: register table, TX waveform, loopback IRQ, and
// randomized RX traffic checked against a queue model of the FIFO.
module tb_io_uart_irq;

  logic        clk = 1'b0;
  logic        reset, io_rd, io_wr;
  logic [15:0] io_addr, io_dout;
  logic [15:0] io_din;
  logic        irq, txd, uart_rxd;
  logic        loop_en, drv_rxd;

  assign uart_rxd = loop_en ? txd : drv_rxd;

  io_uart_irq dut (
    .clk               (clk),
    .reset             (reset),
    .io_rd             (io_rd),
    .io_wr             (io_wr),
    .io_addr           (io_addr),
    .io_dout           (io_dout),
    .io_din            (io_din),
    .interrupt_request (irq),
    .uart_rxd          (uart_rxd),
    .uart_txd          (txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: received bytes in order, plus the two sticky flags.
  logic [7:0] mq[$];
  bit         m_ovf, m_ferr;

  typedef struct {
    logic [1:0]  kind;   // 0 idle sample, 1 read, 2 write
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[14];

  function automatic logic [15:0] ra(input logic [1:0] idx);
    return {8'h10, 5'b00000, idx, 1'b0};
  endfunction

  function automatic logic [15:0] exp_status();
    return {8'(mq.size()), 3'b000, 1'b1, m_ferr, m_ovf, (mq.size() != 0), 1'b1};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic m_push(input logic [7:0] b);
    if (mq.size() == 16) m_ovf = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic bus_wr(input logic [1:0] idx, input logic [15:0] d);
    @(negedge clk);
    io_addr = ra(idx); io_dout = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
    $display("wr reg%0d <= %h", idx, d);
  endtask

  task automatic bus_rd(input logic [1:0] idx, output logic [15:0] d);
    @(negedge clk);
    io_addr = ra(idx); io_rd = 1'b1;
    #1 d = io_din;
    @(negedge clk);
    io_rd = 1'b0;
    $display("rd reg%0d -> %h", idx, d);
  endtask

  // Side-effect-free sample of a register within the current low phase.
  task automatic peek(input logic [1:0] idx, output logic [15:0] d);
    io_addr = ra(idx); io_rd = 1'b1;
    #1 d = io_din;
    io_rd = 1'b0;
  endtask

  // Drive one frame at 4 clocks per bit; optionally pop DATA on the cycle
  // whose closing edge is 41 clocks after the start bit (the push edge).
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit pop_mid, output logic [15:0] popped);
    int bitno;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      bitno = n / 4;
      if (bitno == 0)      drv_rxd = 1'b0;
      else if (bitno == 9) drv_rxd = stop_ok;
      else                 drv_rxd = b[bitno-1];
    end
    @(negedge clk);
    drv_rxd = 1'b1;
    popped = 16'h0000;
    if (pop_mid) begin
      io_addr = ra(2'd0); io_rd = 1'b1;
      #1 popped = io_din;
      @(negedge clk);
      io_rd = 1'b0;
    end
    repeat (6) @(negedge clk);
    $display("rx frame %h stop=%0d pop=%0d", b, stop_ok, pop_mid);
  endtask

  initial begin
    logic [15:0] d, e;
    logic [9:0]  fr;
    logic [7:0]  b;
    bit          seen;
    int          op;

    vt[0]  = '{2'd0, ra(2'd1), 16'h0000, 16'h0000};  // not reading -> 0
    vt[1]  = '{2'd1, ra(2'd1), 16'h0000, 16'h0011};  // STATUS after reset
    vt[2]  = '{2'd1, ra(2'd2), 16'h0000, 16'd103};   // DIV default
    vt[3]  = '{2'd1, ra(2'd3), 16'h0000, 16'h0000};  // IE
    vt[4]  = '{2'd1, ra(2'd0), 16'h0000, 16'h0000};  // DATA empty
    vt[5]  = '{2'd1, 16'h2002, 16'h0000, 16'h0000};  // other base
    vt[6]  = '{2'd2, ra(2'd2), 16'h0003, 16'h0000};
    vt[7]  = '{2'd1, ra(2'd2), 16'h0000, 16'h0003};
    vt[8]  = '{2'd2, ra(2'd3), 16'hFFFC, 16'h0000};
    vt[9]  = '{2'd1, ra(2'd3), 16'h0000, 16'h0000};
    vt[10] = '{2'd2, ra(2'd3), 16'h0001, 16'h0000};
    vt[11] = '{2'd1, ra(2'd3), 16'h0000, 16'h0001};
    vt[12] = '{2'd2, ra(2'd3), 16'h0000, 16'h0000};
    vt[13] = '{2'd1, 16'h10FB, 16'h0000, 16'h0011};  // STATUS, junk low bits

    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0; io_dout = 16'h0;
    loop_en = 1'b0; drv_rxd = 1'b1; m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_txd", {15'h0, txd}, 16'h0001);
    check("rst_irq", {15'h0, irq}, 16'h0000);

    // Register table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      io_addr = vt[i].addr; io_dout = vt[i].wdata;
      io_rd = (vt[i].kind == 2'd1); io_wr = (vt[i].kind == 2'd2);
      #1;
      if (vt[i].kind != 2'd2) check($sformatf("vec%0d", i), io_din, vt[i].exp);
      $display("vec %0d kind=%0d addr=%h", i, vt[i].kind, vt[i].addr);
    end
    @(negedge clk);
    io_rd = 1'b0; io_wr = 1'b0;

    // tx_ready IRQ lags IE write by one clock
    bus_wr(2'd3, 16'h0002);
    check("irq_tx_lag", {15'h0, irq}, 16'h0000);
    @(negedge clk);
    check("irq_tx", {15'h0, irq}, 16'h0001);
    bus_wr(2'd3, 16'h0000);
    @(negedge clk);

    // TX waveform for 0xA5 at DIV=3
    fr = {1'b1, 8'hA5, 1'b0};
    bus_wr(2'd0, 16'h00A5);
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      #1;
      if (t < 40) check($sformatf("txbit t%0d", t), {15'h0, txd}, {15'h0, fr[t/4]});
      if (t == 2)  begin peek(2'd1, d); check("tx_ready_busy", d & 16'h0011, 16'h0001); end
      if (t == 39) begin peek(2'd1, d); check("tx_idle_39", d & 16'h0010, 16'h0000); end
      if (t == 40) begin peek(2'd1, d); check("tx_idle_40", d & 16'h0010, 16'h0010); end
    end

    // Loopback with rx IRQ
    loop_en = 1'b1;
    bus_wr(2'd3, 16'h0001);
    bus_wr(2'd0, 16'h003C);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    check("irq_rx_seen", {15'h0, seen}, 16'h0001);
    bus_rd(2'd0, d);
    check("loop_data", d, 16'h003C);
    check("irq_hold", {15'h0, irq}, 16'h0001);
    @(negedge clk);
    check("irq_drop", {15'h0, irq}, 16'h0000);
    bus_wr(2'd3, 16'h0000);
    loop_en = 1'b0;

    // 17 frames without popping -> overflow
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, d);
      m_push(b);
    end
    @(negedge clk); peek(2'd1, d);
    check("ovf_status", d, exp_status());
    bus_wr(2'd1, 16'h0004);
    m_ovf = 1'b0;
    @(negedge clk); peek(2'd1, d);
    check("ovf_clear", d, exp_status());

    // Full FIFO: pop coincides with push
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1, d);
    e = {8'h00, mq.pop_front()};
    check("coinc_pop", d, e);
    mq.push_back(b);
    @(negedge clk); peek(2'd1, d);
    check("coinc_status", d, exp_status());
    while (mq.size() != 0) begin
      bus_rd(2'd0, d);
      e = {8'h00, mq.pop_front()};
      check("drain", d, e);
    end
    @(negedge clk); peek(2'd1, d);
    check("drained", d, exp_status());

    // Glitch of a quarter bit
    @(negedge clk); drv_rxd = 1'b0;
    @(negedge clk); drv_rxd = 1'b1;
    repeat (60) @(negedge clk);
    peek(2'd1, d);
    check("glitch", d, exp_status());

    // Bad stop bit
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0, d); m_push(b);
    send_frame(8'h5A, 1'b0, 1'b0, d); m_ferr = 1'b1;
    @(negedge clk); peek(2'd1, d);
    check("frame_err", d, exp_status());
    bus_wr(2'd1, 16'h0008);
    m_ferr = 1'b0;
    @(negedge clk); peek(2'd1, d);
    check("ferr_clear", d, exp_status());

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0, 1: begin b = 8'($urandom); send_frame(b, 1'b1, 1'b0, d); m_push(b); end
        2:    begin b = 8'($urandom); send_frame(b, 1'b0, 1'b0, d); m_ferr = 1'b1; end
        3: begin
          bus_rd(2'd0, d);
          e = (mq.size() != 0) ? {8'h00, mq.pop_front()} : 16'h0000;
          check($sformatf("rand_pop%0d", i), d, e);
        end
        default: begin bus_wr(2'd1, 16'h000C); m_ovf = 1'b0; m_ferr = 1'b0; end
      endcase
      @(negedge clk); peek(2'd1, d);
      check($sformatf("rand_status%0d", i), d, exp_status());
    end

    // Reset mid-frame
    bus_wr(2'd0, 16'h0000);
    drv_rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("tx_mid", {15'h0, txd}, 16'h0000);
    reset = 1'b1; drv_rxd = 1'b1;
    @(negedge clk);
    check("rst_mid_txd", {15'h0, txd}, 16'h0001);
    reset = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (60) @(negedge clk);
    peek(2'd1, d);
    check("rst_mid_status", d, exp_status());
    bus_rd(2'd2, d);
    check("rst_mid_div", d, 16'd103);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_uart_irq.md
# io_uart_irq

Memory-mapped UART peripheral that sits directly on the J1 core's IO bus. It decodes `io_rd`/`io_wr`/`io_addr` and drives `io_din` combinationally in the same cycle, as the core latches `io_din` into TOS on the access edge. It provides a single-byte TX holding register plus shifter, an RX FIFO, a programmable baud divisor and a level interrupt request into the core's `interrupt_request` input.

## Interface
Parameters:
- `BASE`, 8'h10: block selected when `io_addr[15:8] == BASE`.
- `RXAW`, 4: RX FIFO address width; depth is 2^RXAW (16).
- `DEFAULT_DIV`, 16'd103: reset baud divisor; bit period is DIV+1 clocks (12 MHz / 115200).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_rd`  in  1  single-cycle read strobe from core.
- `io_wr`  in  1  single-cycle write strobe from core.
- `io_addr`  in  16  IO address; `[15:8]` select, `[2:1]` register index.
- `io_dout`  in  16  write data from core.
- `io_din`  out  16  read data; 16'h0000 whenever not selected or `io_rd` low (wired-OR safe).
- `interrupt_request`  out  1  registered level IRQ to core.
- `uart_rxd`  in  1  asynchronous serial input.
- `uart_txd`  out  1  serial output, idle high.

## Operation
- Registers (index = `io_addr[2:1]`):
  - 0 DATA: write loads TX holding register with `io_dout[7:0]`. Read returns `{8'h00, rx_head}` and pops.
  - 1 STATUS: read gives `[0]` tx_ready (holding empty), `[1]` rx_valid, `[2]` rx_overflow (sticky), `[3]` frame_err (sticky), `[4]` tx_idle (holding and shifter empty), `[15:8]` RX fill count (zero-extended). Write-1-to-clear on bits 2 and 3; other bits ignored.
  - 2 DIV: read/write 16-bit baud divisor.
  - 3 IE: `[0]` rx_valid IRQ enable, `[1]` tx_ready IRQ enable; other bits read 0.
- Writes to DATA while the holding register is full are dropped. Reads of DATA while the FIFO is empty return 0 and do not pop.
- TX FSM: states IDLE, START, DATA, STOP.
  - IDLE → START when holding is full. The byte moves to the shifter and holding empties on the same edge.
  - Each bit lasts DIV+1 clocks; data is sent LSB first, 8 bits.
  - STOP → START directly if holding is full, else → IDLE.
- RX path: `uart_rxd` passes through a 2-flop synchronizer. RX FSM states IDLE, START, DATA, STOP.
  - A falling edge in IDLE starts a frame. The start bit is re-sampled at (DIV+1)>>1 clocks; if it reads high, return to IDLE (glitch).
  - Data bits are sampled every DIV+1 clocks thereafter, LSB first.
  - If the stop bit is 0: discard the byte, set frame_err, go to IDLE.
  - If the stop bit is 1: push the byte to the FIFO. If the FIFO is full, drop the byte and set rx_overflow.
- FIFO full with pop and push in the same cycle: the pop takes effect first, the push succeeds, there is no overflow, and the count is unchanged.
- `interrupt_request` = registered `(IE[0] & rx_valid) | (IE[1] & tx_ready)`.
- A DIV write during a frame takes effect at the next bit-period reload of each counter; the current bit completes with the old value.

## Timing
- Reset values: `uart_txd`=1, `interrupt_request`=0, `io_din`=0, FIFO empty, flags 0, IE=0, DIV=`DEFAULT_DIV`, both FSMs IDLE.
- Reset asserted mid-frame: on the next edge, TX is abandoned (`uart_txd`=1) and the RX partial byte is discarded.
- `io_din` is combinational from `io_addr`, `io_rd` and the current state: zero-cycle read latency. Side effects of a read (pop) occur at the edge that ends the `io_rd` cycle.
- TX write at edge N: holding full after N; shifter loads at N+1; `uart_txd` falls after N+1. A full 10-bit frame lasts 10·(DIV+1) clocks.
- RX latency: rx_valid is set on the edge after the stop-bit sample, which is 9.5·(DIV+1) + 3 clocks after the start edge at the pin (±1).
- IRQ lags its condition by 1 clock. It stays asserted until the condition clears, for example by a pop or a DATA write.
- A simultaneous `io_rd` and `io_wr` is not generated by the core; if it does occur, the write is applied and read data is still returned.

## Test plan
- Reset, then read STATUS → 16'h0011 (tx_ready, tx_idle). Read DIV → 103. `uart_txd`=1.
- Set DIV=3 and write DATA 8'hA5 → `uart_txd` pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks. tx_idle=1 exactly 40 clocks after the shifter load.
- Loop `uart_txd`→`uart_rxd`, set IE=1, send 8'h3C → `interrupt_request` rises. DATA read returns 16'h003C and the IRQ drops 1 clock later.
- Inject 17 frames without popping → count reads 16, rx_overflow=1, and the first 16 bytes are intact. Writing STATUS 16'h0004 clears the flag.
- Send a frame with stop bit 0 → frame_err=1 and the count is unchanged. Send a 1-bit-period/4 low glitch → no frame and no flags.
- With the FIFO full, time a DATA read so it coincides with a push → count stays 16 and no overflow is flagged.
